// File: rtl/rs_alu_queue_if.sv
// Allocation, result-broadcast and issue signals of the ALU reservation queue.
// The queue uses the slave modport; whatever feeds it uses master.
interface rs_alu_queue_if #(
    parameter int NCDB   = 3,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic                   in_valid;
    logic                   in_ready;
    logic [OP_W-1:0]        in_op;
    logic [TAG_W-1:0]       in_tagx;
    logic [TAG_W-1:0]       in_tagy;
    logic [TAG_W-1:0]       in_tagw;
    logic [DATA_W-1:0]      in_datax;
    logic [DATA_W-1:0]      in_datay;

    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*TAG_W-1:0]  cdb_tag;
    logic [NCDB*DATA_W-1:0] cdb_data;

    logic                   issue_valid;
    logic                   issue_ready;
    logic [OP_W-1:0]        issue_op;
    logic [DATA_W-1:0]      issue_datax;
    logic [DATA_W-1:0]      issue_datay;
    logic [TAG_W-1:0]       issue_tagw;

    modport master (
        output in_valid, in_op, in_tagx, in_tagy, in_tagw, in_datax, in_datay,
        output cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  in_ready, issue_valid, issue_op, issue_datax, issue_datay, issue_tagw
    );

    modport slave (
        input  in_valid, in_op, in_tagx, in_tagy, in_tagw, in_datax, in_datay,
        input  cdb_valid, cdb_tag, cdb_data, issue_ready,
        output in_ready, issue_valid, issue_op, issue_datax, issue_datay, issue_tagw
    );
endinterface

// File: rtl/rs_alu_queue.sv
// Collapsing, age-ordered ALU reservation station: oldest ready entry issues,
// younger entries shift down, operand tags wake up from the result broadcast ports.
module rs_alu_queue #(
    parameter int DEPTH    = 4,
    parameter int NCDB     = 3,
    parameter int TAG_W    = 5,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 6,
    parameter int UNLOCKED = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    rs_alu_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] UNLOCKED_TAG = TAG_W'(UNLOCKED);
    localparam logic [CW-1:0]    DEPTH_C      = CW'(DEPTH);

    logic [OP_W-1:0]   op_reg    [DEPTH];
    logic [TAG_W-1:0]  tagx_reg  [DEPTH];
    logic [TAG_W-1:0]  tagy_reg  [DEPTH];
    logic [TAG_W-1:0]  tagw_reg  [DEPTH];
    logic [DATA_W-1:0] datax_reg [DEPTH];
    logic [DATA_W-1:0] datay_reg [DEPTH];
    logic [CW-1:0]     count_reg;

    logic [OP_W-1:0]   op_next    [DEPTH];
    logic [TAG_W-1:0]  tagx_next  [DEPTH];
    logic [TAG_W-1:0]  tagy_next  [DEPTH];
    logic [TAG_W-1:0]  tagw_next  [DEPTH];
    logic [DATA_W-1:0] datax_next [DEPTH];
    logic [DATA_W-1:0] datay_next [DEPTH];
    logic [CW-1:0]     count_next;

    // Index DEPTH holds the incoming instruction so it wakes up like a stored entry.
    logic [TAG_W-1:0]  cand_tagx  [DEPTH+1];
    logic [TAG_W-1:0]  cand_tagy  [DEPTH+1];
    logic [DATA_W-1:0] cand_datax [DEPTH+1];
    logic [DATA_W-1:0] cand_datay [DEPTH+1];
    logic [DATA_W:0]   hit_x      [DEPTH+1];
    logic [DATA_W:0]   hit_y      [DEPTH+1];
    logic [TAG_W-1:0]  wake_tagx  [DEPTH+1];
    logic [TAG_W-1:0]  wake_tagy  [DEPTH+1];
    logic [DATA_W-1:0] wake_datax [DEPTH+1];
    logic [DATA_W-1:0] wake_datay [DEPTH+1];

    logic [DEPTH-1:0]  entry_ready;
    logic [IW-1:0]     sel_idx;
    logic              any_ready;
    logic              fire;
    logic              alloc;
    logic [CW-1:0]     wr_pos;

    // Returns {hit, data}; the descending scan lets the lowest matching port win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]       tag,
        input logic [NCDB-1:0]        valid,
        input logic [NCDB*TAG_W-1:0]  tags,
        input logic [NCDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] res;
        res = '0;
        if (tag != UNLOCKED_TAG) begin
            for (int k = NCDB - 1; k >= 0; k--) begin
                if (valid[k] && (tags[k*TAG_W +: TAG_W] == tag))
                    res = {1'b1, data[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign cand_tagx[gi]   = tagx_reg[gi];
        assign cand_tagy[gi]   = tagy_reg[gi];
        assign cand_datax[gi]  = datax_reg[gi];
        assign cand_datay[gi]  = datay_reg[gi];
        assign entry_ready[gi] = (count_reg > CW'(gi)) &&
                                 (tagx_reg[gi] == UNLOCKED_TAG) &&
                                 (tagy_reg[gi] == UNLOCKED_TAG);
    end

    assign cand_tagx[DEPTH]  = bus.in_tagx;
    assign cand_tagy[DEPTH]  = bus.in_tagy;
    assign cand_datax[DEPTH] = bus.in_datax;
    assign cand_datay[DEPTH] = bus.in_datay;

    for (genvar gi = 0; gi <= DEPTH; gi++) begin : g_wake
        assign hit_x[gi]      = cdb_lookup(cand_tagx[gi], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        assign hit_y[gi]      = cdb_lookup(cand_tagy[gi], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        assign wake_tagx[gi]  = hit_x[gi][DATA_W] ? UNLOCKED_TAG : cand_tagx[gi];
        assign wake_tagy[gi]  = hit_y[gi][DATA_W] ? UNLOCKED_TAG : cand_tagy[gi];
        assign wake_datax[gi] = hit_x[gi][DATA_W] ? hit_x[gi][DATA_W-1:0] : cand_datax[gi];
        assign wake_datay[gi] = hit_y[gi][DATA_W] ? hit_y[gi][DATA_W-1:0] : cand_datay[gi];
    end

    always_comb begin
        sel_idx   = '0;
        any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_ready[i]) begin
                sel_idx   = IW'(i);
                any_ready = 1'b1;
            end
        end
    end

    // Issue data comes from stored operands only, so a wakeup is visible one cycle later.
    assign bus.issue_valid = rdy && any_ready;
    assign bus.issue_op    = any_ready ? op_reg[sel_idx]    : '0;
    assign bus.issue_datax = any_ready ? datax_reg[sel_idx] : '0;
    assign bus.issue_datay = any_ready ? datay_reg[sel_idx] : '0;
    assign bus.issue_tagw  = any_ready ? tagw_reg[sel_idx]  : '0;

    assign bus.in_ready = rdy && !flush && (count_reg < DEPTH_C);
    assign fire         = bus.issue_valid && bus.issue_ready;
    assign alloc        = bus.in_valid && bus.in_ready;
    assign wr_pos       = count_reg - CW'(fire);
    assign count        = count_reg;

    always_comb begin
        count_next = count_reg;
        for (int i = 0; i < DEPTH; i++) begin
            op_next[i]    = op_reg[i];
            tagx_next[i]  = tagx_reg[i];
            tagy_next[i]  = tagy_reg[i];
            tagw_next[i]  = tagw_reg[i];
            datax_next[i] = datax_reg[i];
            datay_next[i] = datay_reg[i];
        end
        if (flush) begin
            count_next = '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_next[i]    = '0;
                tagx_next[i]  = UNLOCKED_TAG;
                tagy_next[i]  = UNLOCKED_TAG;
                tagw_next[i]  = '0;
                datax_next[i] = '0;
                datay_next[i] = '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // Entries above the issued one move down and still take this edge's wakeup.
                if (fire && (i >= int'(sel_idx))) begin
                    if (i == DEPTH - 1) begin
                        op_next[i]    = '0;
                        tagx_next[i]  = UNLOCKED_TAG;
                        tagy_next[i]  = UNLOCKED_TAG;
                        tagw_next[i]  = '0;
                        datax_next[i] = '0;
                        datay_next[i] = '0;
                    end else begin
                        op_next[i]    = op_reg[i+1];
                        tagx_next[i]  = wake_tagx[i+1];
                        tagy_next[i]  = wake_tagy[i+1];
                        tagw_next[i]  = tagw_reg[i+1];
                        datax_next[i] = wake_datax[i+1];
                        datay_next[i] = wake_datay[i+1];
                    end
                end else begin
                    tagx_next[i]  = wake_tagx[i];
                    tagy_next[i]  = wake_tagy[i];
                    datax_next[i] = wake_datax[i];
                    datay_next[i] = wake_datay[i];
                end
                if (alloc && (CW'(i) == wr_pos)) begin
                    op_next[i]    = bus.in_op;
                    tagx_next[i]  = wake_tagx[DEPTH];
                    tagy_next[i]  = wake_tagy[DEPTH];
                    tagw_next[i]  = bus.in_tagw;
                    datax_next[i] = wake_datax[DEPTH];
                    datay_next[i] = wake_datay[DEPTH];
                end
            end
            count_next = count_reg + CW'(alloc) - CW'(fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_reg[i]    <= '0;
                tagx_reg[i]  <= UNLOCKED_TAG;
                tagy_reg[i]  <= UNLOCKED_TAG;
                tagw_reg[i]  <= '0;
                datax_reg[i] <= '0;
                datay_reg[i] <= '0;
            end
        end else if (rdy) begin
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                op_reg[i]    <= op_next[i];
                tagx_reg[i]  <= tagx_next[i];
                tagy_reg[i]  <= tagy_next[i];
                tagw_reg[i]  <= tagw_next[i];
                datax_reg[i] <= datax_next[i];
                datay_reg[i] <= datay_next[i];
            end
        end
    end
endmodule

// File: tb/tb_rs_alu_queue.sv
// Bench for rs_alu_queue: directed scenarios plus random traffic checked
// against an age-ordered queue model of the reservation station.
module tb_rs_alu_queue;
    localparam int DEPTH  = 4;
    localparam int NCDB   = 3;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          flush;
    logic [CW-1:0] count;
    int            checks   = 0;
    int            failures = 0;

    rs_alu_queue_if #(.NCDB(NCDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    rs_alu_queue #(
        .DEPTH(DEPTH), .NCDB(NCDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .UNLOCKED(0)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tx;
        logic [TAG_W-1:0]  ty;
        logic [TAG_W-1:0]  tw;
        logic [DATA_W-1:0] dx;
        logic [DATA_W-1:0] dy;
    } ent_t;

    ent_t mq[$];   // index 0 = oldest

    function automatic int model_sel();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tx == '0 && mq[i].ty == '0) return i;
        return -1;
    endfunction

    // An operand waiting on tag t takes the value of the lowest port broadcasting t.
    function automatic void wake(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                                 output logic [TAG_W-1:0] t_out, output logic [DATA_W-1:0] d_out);
        t_out = t;
        d_out = d;
        if (t != '0) begin
            for (int k = 0; k < NCDB; k++) begin
                if (bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == t) begin
                    t_out = '0;
                    d_out = bus.cdb_data[k*DATA_W +: DATA_W];
                    break;
                end
            end
        end
    endfunction

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0;
        bus.in_tagx = '0; bus.in_tagy = '0; bus.in_tagw = '0;
        bus.in_datax = '0; bus.in_datay = '0;
        bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.issue_ready = 1'b0;
    endtask

    task automatic put(input int op, input int tx, input int ty, input int tw, input int dx, input int dy);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_W'(op);
        bus.in_tagx  = TAG_W'(tx);
        bus.in_tagy  = TAG_W'(ty);
        bus.in_tagw  = TAG_W'(tw);
        bus.in_datax = DATA_W'(dx);
        bus.in_datay = DATA_W'(dy);
    endtask

    task automatic cdb(input int k, input int tag, input int data);
        bus.cdb_valid[k]                     = 1'b1;
        bus.cdb_tag[k*TAG_W +: TAG_W]        = TAG_W'(tag);
        bus.cdb_data[k*DATA_W +: DATA_W]     = DATA_W'(data);
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        int   sel;
        logic fire;
        logic alloc;
        ent_t e;
        sel   = model_sel();
        fire  = rdy && (sel >= 0) && bus.issue_ready;
        alloc = bus.in_valid && rdy && !flush && (mq.size() < DEPTH);
        if (fire && !rst && !flush)
            $display("issue op=%0h tagw=%0h x=%0h y=%0h", bus.issue_op, bus.issue_tagw, bus.issue_datax, bus.issue_datay);
        @(posedge clk);
        if (rst) mq.delete();
        else if (rdy) begin
            if (flush) mq.delete();
            else begin
                if (fire) mq.delete(sel);
                for (int i = 0; i < mq.size(); i++) begin
                    e = mq[i];
                    wake(e.tx, e.dx, e.tx, e.dx);
                    wake(e.ty, e.dy, e.ty, e.dy);
                    mq[i] = e;
                end
                if (alloc) begin
                    e.op = bus.in_op; e.tw = bus.in_tagw;
                    wake(bus.in_tagx, bus.in_datax, e.tx, e.dx);
                    wake(bus.in_tagy, bus.in_datay, e.ty, e.dy);
                    mq.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; rdy = 1'b0;
        tick(); tick();
        idle(); #1;
        checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0h exp=0", bus.issue_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", bus.in_ready); end
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({bus.issue_op, bus.issue_datax, bus.issue_datay, bus.issue_tagw} !== '0) begin failures++;
            $display("FAIL reset_issue_fields got op=%0h x=%0h y=%0h w=%0h exp=0", bus.issue_op, bus.issue_datax, bus.issue_datay, bus.issue_tagw); end
    endtask

    task automatic test_basic();
        idle(); bus.issue_ready = 1'b1;
        put(3, 0, 0, 9, 5, 7);
        cdb(0, 0, 'h99);   // an UNLOCKED broadcast must not touch the operands
        #1;
        checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL basic_empty_valid got=%0h exp=0", bus.issue_valid); end
        tick();
        idle(); bus.issue_ready = 1'b1; #1;
        checks++; if (bus.issue_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", bus.issue_valid); end
        checks++; if (bus.issue_op !== OP_W'(3)) begin failures++; $display("FAIL basic_op got=%0h exp=3", bus.issue_op); end
        checks++; if (bus.issue_datax !== DATA_W'(5)) begin failures++; $display("FAIL basic_datax got=%0h exp=5", bus.issue_datax); end
        checks++; if (bus.issue_datay !== DATA_W'(7)) begin failures++; $display("FAIL basic_datay got=%0h exp=7", bus.issue_datay); end
        checks++; if (bus.issue_tagw !== TAG_W'(9)) begin failures++; $display("FAIL basic_tagw got=%0h exp=9", bus.issue_tagw); end
        tick(); #1;
        checks++; if (count !== '0) begin failures++; $display("FAIL basic_count got=%0d exp=0", count); end
    endtask

    task automatic test_wakeup();
        idle(); bus.issue_ready = 1'b1;
        put(1, 4, 0, 11, 0, 'h22);
        tick();
        idle(); bus.issue_ready = 1'b1;
        cdb(1, 4, 'hAA); #1;
        checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_no_bypass got=%0h exp=0", bus.issue_valid); end
        tick();
        bus.cdb_valid = '0; #1;
        checks++; if (bus.issue_valid !== 1'b1) begin failures++; $display("FAIL wake_valid got=%0h exp=1", bus.issue_valid); end
        checks++; if (bus.issue_datax !== DATA_W'('hAA)) begin failures++; $display("FAIL wake_datax got=%0h exp=aa", bus.issue_datax); end
        checks++; if (bus.issue_datay !== DATA_W'('h22)) begin failures++; $display("FAIL wake_datay got=%0h exp=22", bus.issue_datay); end
        tick(); #1;
        checks++; if (count !== '0) begin failures++; $display("FAIL wake_count got=%0d exp=0", count); end
    endtask

    task automatic test_order();
        idle();
        put(1, 6, 0, 1, 0, 0); tick();
        put(2, 0, 0, 2, 0, 0); tick();
        put(3, 0, 0, 3, 0, 0); tick();
        idle(); bus.issue_ready = 1'b1; #1;
        checks++; if (bus.issue_tagw !== TAG_W'(2) || bus.issue_valid !== 1'b1) begin failures++; $display("FAIL order_first got=%0h exp=2", bus.issue_tagw); end
        tick(); #1;
        checks++; if (bus.issue_tagw !== TAG_W'(3) || bus.issue_valid !== 1'b1) begin failures++; $display("FAIL order_second got=%0h exp=3", bus.issue_tagw); end
        tick(); #1;
        checks++; if (bus.issue_valid !== 1'b0 || count !== CW'(1)) begin failures++; $display("FAIL order_wait got valid=%0h count=%0d exp valid=0 count=1", bus.issue_valid, count); end
        cdb(2, 6, 'h66); tick();
        bus.cdb_valid = '0; #1;
        checks++; if (bus.issue_tagw !== TAG_W'(1) || bus.issue_datax !== DATA_W'('h66)) begin failures++;
            $display("FAIL order_third got tagw=%0h x=%0h exp tagw=1 x=66", bus.issue_tagw, bus.issue_datax); end
        tick();
    endtask

    task automatic test_full();
        idle(); bus.issue_ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin put(j, 2, 0, 10 + j, 0, j); tick(); end
        put(9, 0, 0, 31, 1, 1); #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0h exp=0", bus.in_ready); end
        checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
        tick(); #1;
        checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL full_ignored got=%0d exp=%0d", count, DEPTH); end
        bus.in_valid = 1'b0; cdb(0, 2, 'h5A); tick();
        bus.cdb_valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            #1;
            checks++; if (bus.issue_valid !== 1'b1 || bus.issue_tagw !== TAG_W'(10 + j) || bus.issue_datax !== DATA_W'('h5A)) begin failures++;
                $display("FAIL full_drain%0d got valid=%0h tagw=%0h x=%0h exp valid=1 tagw=%0h x=5a", j, bus.issue_valid, bus.issue_tagw, bus.issue_datax, 10 + j); end
            if (j == 1) begin
                checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_reopen got=%0h exp=1", bus.in_ready); end
            end
            tick();
        end
        #1;
        checks++; if (count !== '0) begin failures++; $display("FAIL full_empty got=%0d exp=0", count); end
    endtask

    task automatic test_bypass();
        idle();
        put(5, 0, 3, 20, 1, 'hDEAD);
        cdb(0, 3, 'h11); cdb(2, 3, 'h22);
        tick();
        idle(); #1;
        checks++; if (bus.issue_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%0h exp=1", bus.issue_valid); end
        checks++; if (bus.issue_datay !== DATA_W'('h11)) begin failures++; $display("FAIL bypass_datay got=%0h exp=11", bus.issue_datay); end
        bus.issue_ready = 1'b1; tick();
    endtask

    task automatic test_flush();
        idle();
        for (int j = 0; j < 3; j++) begin put(j, 7, 0, j, 0, 0); tick(); end
        flush = 1'b1; put(1, 0, 0, 4, 1, 1); bus.issue_ready = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0h exp=0", bus.in_ready); end
        tick();
        idle(); #1;
        checks++; if (count !== '0 || bus.issue_valid !== 1'b0) begin failures++;
            $display("FAIL flush_clear got count=%0d valid=%0h exp count=0 valid=0", count, bus.issue_valid); end
    endtask

    task automatic test_rdy_and_rst();
        idle();
        put(1, 0, 0, 1, 1, 1); tick();
        put(2, 0, 0, 2, 2, 2); tick();
        rdy = 1'b0; bus.issue_ready = 1'b1; put(3, 0, 0, 3, 3, 3); #1;
        checks++; if (bus.issue_valid !== 1'b0 || bus.in_ready !== 1'b0) begin failures++;
            $display("FAIL stall_handshake got valid=%0h in_ready=%0h exp 0 0", bus.issue_valid, bus.in_ready); end
        tick(); #1;
        checks++; if (count !== CW'(2)) begin failures++; $display("FAIL stall_count got=%0d exp=2", count); end
        rst = 1'b1; tick();
        idle(); #1;
        checks++; if (count !== '0 || bus.issue_valid !== 1'b0) begin failures++;
            $display("FAIL rst_mid got count=%0d valid=%0h exp count=0 valid=0", count, bus.issue_valid); end
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.in_op    = OP_W'($urandom);
            bus.in_tagx  = TAG_W'($urandom_range(0, 3));
            bus.in_tagy  = TAG_W'($urandom_range(0, 3));
            bus.in_tagw  = TAG_W'($urandom);
            bus.in_datax = $urandom;
            bus.in_datay = $urandom;
            bus.issue_ready = ($urandom_range(0, 3) != 0);
            bus.cdb_valid   = NCDB'($urandom);
            for (int k = 0; k < NCDB; k++) begin
                bus.cdb_tag[k*TAG_W +: TAG_W]    = TAG_W'($urandom_range(0, 3));
                bus.cdb_data[k*DATA_W +: DATA_W] = $urandom;
            end
            #1;
            s = model_sel();
            checks++; if (bus.issue_valid !== (rdy && s >= 0)) begin failures++;
                $display("FAIL rand_valid n=%0d got=%0h exp=%0h", n, bus.issue_valid, (rdy && s >= 0)); end
            checks++; if (bus.in_ready !== (rdy && !flush && mq.size() < DEPTH)) begin failures++;
                $display("FAIL rand_in_ready n=%0d got=%0h", n, bus.in_ready); end
            checks++; if (count !== CW'(mq.size())) begin failures++;
                $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, count, mq.size()); end
            if (rdy && s >= 0) begin
                checks++; if (bus.issue_op !== mq[s].op || bus.issue_tagw !== mq[s].tw ||
                              bus.issue_datax !== mq[s].dx || bus.issue_datay !== mq[s].dy) begin failures++;
                    $display("FAIL rand_issue n=%0d got op=%0h w=%0h x=%0h y=%0h exp op=%0h w=%0h x=%0h y=%0h", n,
                             bus.issue_op, bus.issue_tagw, bus.issue_datax, bus.issue_datay, mq[s].op, mq[s].tw, mq[s].dx, mq[s].dy); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_order();
        test_full();
        test_bypass();
        test_flush();
        test_rdy_and_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
